// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register and register-file write-back selector.
// Latches the MEM-stage results and write-back controls, selects the write-back
// source and raises a sticky end-of-program flag when a HALT retires.
// Optional build macro: MEM_WB_RETIRE_CNT_EN adds the saturating o_retired_cnt port.
module mem_wb_stage #(
    parameter int IO_BUS_SIZE   = 32,
    parameter int REG_ADDR_SIZE = 5,
    parameter int CNT_SIZE      = 32
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_enable,
    input  logic                     i_flush,
    input  logic                     i_valid,
    input  logic                     i_reg_wr,
    input  logic                     i_mem_to_reg,
    input  logic                     i_link,
    input  logic                     i_halt,
    input  logic [REG_ADDR_SIZE-1:0] i_rd_addr,
    input  logic [IO_BUS_SIZE-1:0]   i_mem_rd,
    input  logic [IO_BUS_SIZE-1:0]   i_alu_result,
    input  logic [IO_BUS_SIZE-1:0]   i_return_addr,
    output logic                     o_reg_wr,
    output logic [REG_ADDR_SIZE-1:0] o_rd_addr,
    output logic [IO_BUS_SIZE-1:0]   o_wb_data,
    output logic                     o_valid,
    output logic                     o_end_program
`ifdef MEM_WB_RETIRE_CNT_EN
    ,
    output logic [CNT_SIZE-1:0]      o_retired_cnt
`endif
);

    logic                     vld_p1;
    logic                     reg_wr_p1;
    logic                     mem_to_reg_p1;
    logic                     link_p1;
    logic                     halt_p1;
    logic                     end_prog_p1;
    logic [REG_ADDR_SIZE-1:0] rd_addr_p1;
    logic [IO_BUS_SIZE-1:0]   mem_rd_p1;
    logic [IO_BUS_SIZE-1:0]   alu_result_p1;
    logic [IO_BUS_SIZE-1:0]   return_addr_p1;

    // Once the HALT has retired the stage is frozen; flush beats enable.
    logic capture;
    assign capture = ~end_prog_p1 & ~i_flush & i_enable;

    // MEM -> WB boundary: latch instruction fields (flush only kills the control bits).
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            vld_p1         <= 1'b0;
            reg_wr_p1      <= 1'b0;
            mem_to_reg_p1  <= 1'b0;
            link_p1        <= 1'b0;
            halt_p1        <= 1'b0;
            rd_addr_p1     <= '0;
            mem_rd_p1      <= '0;
            alu_result_p1  <= '0;
            return_addr_p1 <= '0;
        end else if (!end_prog_p1) begin
            if (i_flush) begin
                vld_p1    <= 1'b0;
                reg_wr_p1 <= 1'b0;
                halt_p1   <= 1'b0;
            end else if (i_enable) begin
                vld_p1         <= i_valid;
                reg_wr_p1      <= i_reg_wr;
                mem_to_reg_p1  <= i_mem_to_reg;
                link_p1        <= i_link;
                halt_p1        <= i_halt;
                rd_addr_p1     <= i_rd_addr;
                mem_rd_p1      <= i_mem_rd;
                alu_result_p1  <= i_alu_result;
                return_addr_p1 <= i_return_addr;
            end
        end
    end

    // Sticky end-of-program: set by the edge that captures a valid HALT, cleared only by reset.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            end_prog_p1 <= 1'b0;
        end else if (capture && i_valid && i_halt) begin
            end_prog_p1 <= 1'b1;
        end
    end

`ifdef MEM_WB_RETIRE_CNT_EN
    function automatic logic [CNT_SIZE-1:0] sat_inc(input logic [CNT_SIZE-1:0] v);
        return (&v) ? v : v + CNT_SIZE'(1);
    endfunction

    logic [CNT_SIZE-1:0] retired_cnt_p1;

    // Count retired non-HALT instructions, holding at all ones.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            retired_cnt_p1 <= '0;
        end else if (capture && i_valid && !i_halt) begin
            retired_cnt_p1 <= sat_inc(retired_cnt_p1);
        end
    end

    assign o_retired_cnt = retired_cnt_p1;
`endif

    // Write-back source select: link beats memory, memory beats ALU.
    always_comb begin
        o_wb_data = alu_result_p1;
        if (link_p1) begin
            o_wb_data = return_addr_p1;
        end else if (mem_to_reg_p1) begin
            o_wb_data = mem_rd_p1;
        end
    end

    // $zero is never written, nor is the HALT slot or anything after it.
    assign o_reg_wr      = vld_p1 & reg_wr_p1 & (rd_addr_p1 != '0) & ~halt_p1 & ~end_prog_p1;
    assign o_rd_addr     = rd_addr_p1;
    assign o_valid       = vld_p1;
    assign o_end_program = end_prog_p1;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Testbench for mem_wb_stage: directed scenarios plus randomized traffic,
// checked against a transaction-level model of the write-back stage.
module tb_mem_wb_stage;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          en, flush, valid, reg_wr, m2r, link, halt;
    logic [AW-1:0] rd;
    logic [DW-1:0] mem_rd, alu, ret;
    logic          o_reg_wr, o_valid, o_end;
    logic [AW-1:0] o_rd;
    logic [DW-1:0] o_wb;
`ifdef MEM_WB_RETIRE_CNT_EN
    logic [CW-1:0] o_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // Model: the instruction currently sitting in write-back, plus program state.
    typedef struct {
        bit          valid;
        bit          reg_wr;
        bit          halt;
        bit [AW-1:0] rd;
        bit [DW-1:0] result;   // value the instruction will write back
    } slot_t;

    slot_t       m_slot;
    bit          m_end;
    int          m_retired;

    mem_wb_stage #(
        .IO_BUS_SIZE  (DW),
        .REG_ADDR_SIZE(AW),
        .CNT_SIZE     (CW)
    ) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_enable     (en),
        .i_flush      (flush),
        .i_valid      (valid),
        .i_reg_wr     (reg_wr),
        .i_mem_to_reg (m2r),
        .i_link       (link),
        .i_halt       (halt),
        .i_rd_addr    (rd),
        .i_mem_rd     (mem_rd),
        .i_alu_result (alu),
        .i_return_addr(ret),
        .o_reg_wr     (o_reg_wr),
        .o_rd_addr    (o_rd),
        .o_wb_data    (o_wb),
        .o_valid      (o_valid),
        .o_end_program(o_end)
`ifdef MEM_WB_RETIRE_CNT_EN
        ,
        .o_retired_cnt(o_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_slot    = '{valid: 0, reg_wr: 0, halt: 0, rd: '0, result: '0};
        m_end     = 0;
        m_retired = 0;
    endfunction

    // What the instruction presented this cycle would write back.
    function automatic bit [DW-1:0] chosen_result();
        if (link) return ret;
        if (m2r)  return mem_rd;
        return alu;
    endfunction

    function automatic void model_edge();
        if (m_end) return;
        if (flush) begin
            m_slot.valid  = 0;
            m_slot.reg_wr = 0;
            m_slot.halt   = 0;
        end else if (en) begin
            m_slot = '{valid: valid, reg_wr: reg_wr, halt: halt, rd: rd, result: chosen_result()};
            if (valid && halt) m_end = 1;
            if (valid && !halt && m_retired < (1 << CW) - 1) m_retired++;
        end
    endfunction

    task automatic check_all(input string tag);
        bit exp_wr;
        exp_wr = m_slot.valid && m_slot.reg_wr && m_slot.rd != 0 && !m_slot.halt && !m_end;
        chk({tag, ".reg_wr"}, 64'(o_reg_wr), 64'(exp_wr));
        chk({tag, ".rd"},     64'(o_rd),     64'(m_slot.rd));
        chk({tag, ".wb"},     64'(o_wb),     64'(m_slot.result));
        chk({tag, ".valid"},  64'(o_valid),  64'(m_slot.valid));
        chk({tag, ".end"},    64'(o_end),    64'(m_end));
`ifdef MEM_WB_RETIRE_CNT_EN
        chk({tag, ".cnt"},    64'(o_cnt),    64'(m_retired));
`endif
    endtask

    task automatic drive(input bit v, input bit w, input bit mr, input bit lk, input bit h,
                         input bit [AW-1:0] r, input bit [DW-1:0] md, input bit [DW-1:0] a,
                         input bit [DW-1:0] ra, input bit e, input bit f);
        valid = v; reg_wr = w; m2r = mr; link = lk; halt = h;
        rd = r; mem_rd = md; alu = a; ret = ra; en = e; flush = f;
    endtask

    task automatic drive_random(input int halt_pct);
        drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0),
              $urandom_range(0, 99) < halt_pct, AW'($urandom), $urandom, $urandom, $urandom,
              $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0);
    endtask

    // One clock: inputs are stable across the rising edge, outputs checked on the falling edge.
    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        repeat (n) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, '0, '0, '0, '0, 0, 0);
        model_reset();

        // Reset for a random number of ticks.
        do_reset($urandom_range(1, 20));
        check_all("reset");

        // ALU write-back.
        drive(1, 1, 0, 0, 0, 5, 32'h0, 32'h0000_00A5, 32'h0, 1, 0);
        tick("alu");
        chk("alu.reg_wr_is_1", 64'(o_reg_wr), 64'd1);
        chk("alu.wb_is_a5",    64'(o_wb),     64'h0000_00A5);

        // Memory source, then link source, then $zero suppression.
        drive(1, 1, 1, 0, 0, 9, 32'hFFFF_FF80, 32'h10, 32'h48, 1, 0);
        tick("mem");
        chk("mem.wb_is_ff80", 64'(o_wb), 64'hFFFF_FF80);
        link = 1;
        tick("link");
        chk("link.wb_is_48", 64'(o_wb), 64'h48);
        rd = 0;
        tick("zero");
        chk("zero.reg_wr_is_0", 64'(o_reg_wr), 64'd0);

        // Stall holds rd=7, then flush together with enable.
        drive(1, 1, 0, 0, 0, 7, 32'h0, 32'h77, 32'h0, 1, 0);
        tick("cap7");
        for (int i = 0; i < 5; i++) begin
            drive_random(0);
            en = 0; flush = 0;
            tick("stall");
            chk("stall.rd_is_7", 64'(o_rd), 64'd7);
        end
        drive(1, 1, 0, 0, 0, 3, 32'h0, 32'h33, 32'h0, 1, 1);
        tick("flush");
        chk("flush.valid_is_0",  64'(o_valid),  64'd0);
        chk("flush.reg_wr_is_0", 64'(o_reg_wr), 64'd0);

        // Flush and halt together records no halt.
        drive(1, 1, 0, 0, 1, 4, 32'h0, 32'h1, 32'h0, 1, 1);
        tick("flush_halt");
        chk("flush_halt.end_is_0", 64'(o_end), 64'd0);

        // Reset asserted between edges drops the held instruction immediately.
        drive(1, 1, 0, 0, 0, 12, 32'h0, 32'hC0FFEE, 32'h0, 1, 0);
        tick("pre_async");
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("async.valid_is_0",  64'(o_valid),  64'd0);
        chk("async.reg_wr_is_0", 64'(o_reg_wr), 64'd0);
        chk("async.wb_is_0",     64'(o_wb),     64'd0);
        @(negedge clk);
        rst = 1'b0;

        // HALT: three writes, HALT, four more writes that must be ignored.
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, 0, 0, AW'(i + 1), 32'h0, 32'(100 + i), 32'h0, 1, 0);
            tick("pre_halt");
        end
        drive(1, 0, 0, 0, 1, 0, 32'h0, 32'h0, 32'h0, 1, 0);
        tick("halt");
        chk("halt.end_is_1", 64'(o_end), 64'd1);
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 0, 0, 0, AW'(i + 20), 32'h0, 32'(200 + i), 32'h0, 1, i == 2);
            tick("post_halt");
            chk("post_halt.reg_wr_is_0", 64'(o_reg_wr), 64'd0);
            chk("post_halt.end_is_1",    64'(o_end),    64'd1);
        end
`ifdef MEM_WB_RETIRE_CNT_EN
        chk("halt.cnt_is_3", 64'(o_cnt), 64'd3);
`endif
        do_reset(1);
        chk("halt_reset.end_is_0", 64'(o_end), 64'd0);
        check_all("halt_reset");

        // Counter saturation.
        for (int i = 0; i < 20; i++) begin
            drive(1, 1, 0, 0, 0, AW'(i), 32'h0, 32'(i), 32'h0, 1, 0);
            tick("sat");
        end
`ifdef MEM_WB_RETIRE_CNT_EN
        chk("sat.cnt_is_f", 64'(o_cnt), 64'hF);
`endif

        // Randomized traffic with occasional HALTs and resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                do_reset($urandom_range(1, 3));
                check_all("rnd_reset");
            end
            drive_random(3);
            tick("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Pipeline register and write-back selector between the MEM stage and the register file.
- Captures the data-memory read value, the ALU result, the return address and the write-back controls on each enabled clock edge.
- Drives the register-file write port: write enable, destination address and write data.
- Detects the HALT marker reaching write-back and raises a sticky end-of-program flag that freezes the stage.

Parameters:
- IO_BUS_SIZE, 32, width of the data buses (memory read data, ALU result, return address, write-back data).
- REG_ADDR_SIZE, 5, width of the register-file destination address.
- CNT_SIZE, 32, width of the retired-instruction counter (only used when MEM_WB_RETIRE_CNT_EN is defined).

Ports:
- i_clk  in  1  system clock, rising-edge active.
- i_reset  in  1  asynchronous, active-high reset.
- i_enable  in  1  1 = capture inputs on this edge; 0 = hold (stall).
- i_flush  in  1  1 = load a bubble on this edge; has priority over i_enable.
- i_valid  in  1  incoming slot holds a real instruction.
- i_reg_wr  in  1  instruction writes the register file.
- i_mem_to_reg  in  1  write-back source is memory read data.
- i_link  in  1  write-back source is the return address (JAL/JALR); has priority over i_mem_to_reg.
- i_halt  in  1  instruction is HALT.
- i_rd_addr  in  REG_ADDR_SIZE  destination register.
- i_mem_rd  in  IO_BUS_SIZE  MEM-stage load data (already sign/zero extended).
- i_alu_result  in  IO_BUS_SIZE  MEM-stage ALU result pass-through.
- i_return_addr  in  IO_BUS_SIZE  PC+8 for link instructions.
- o_reg_wr  out  1  register-file write enable.
- o_rd_addr  out  REG_ADDR_SIZE  register-file write address.
- o_wb_data  out  IO_BUS_SIZE  register-file write data.
- o_valid  out  1  latched slot holds a real instruction.
- o_end_program  out  1  sticky HALT-retired flag.
- o_retired_cnt  out  CNT_SIZE  retired-instruction count (present only with MEM_WB_RETIRE_CNT_EN).

Behaviour:
- Reset (asynchronous, i_reset=1):
  - All latched fields clear to 0.
  - o_reg_wr=0, o_rd_addr=0, o_wb_data=0, o_valid=0, o_end_program=0, o_retired_cnt=0.
  - Reset asserted mid-stream discards the held instruction immediately, without waiting for a clock edge.
- Per rising edge, priority order:
  1. If o_end_program=1: freeze and capture nothing. All inputs, including i_flush, are ignored.
  2. Else if i_flush: valid=0, reg_wr=0, halt=0. Data fields may keep stale values.
  3. Else if i_enable: capture all i_* fields.
  4. Else: hold all fields.
- Latency: exactly 1 clock from capture to the outputs.
- o_wb_data (combinational from latched fields):
  - link=1 → return_addr
  - else mem_to_reg=1 → mem_rd
  - else alu_result
- o_reg_wr = valid & reg_wr & (rd_addr != 0) & ~o_end_program. Writes to $zero are always suppressed.
- o_rd_addr and o_wb_data show the latched values whether or not o_reg_wr is asserted.
- HALT handling:
  - If the edge captures valid=1 and halt=1, o_end_program rises in that same cycle (registered alongside the capture).
  - It stays high until reset.
  - The HALT slot itself never writes: o_reg_wr=0 while halt is latched.
- Simultaneous i_flush and i_enable: flush wins.
- Simultaneous i_halt and i_flush: no halt is recorded.
- Stall (i_enable=0) holds o_reg_wr at its current value. The register file sees a repeated write of the same value, which is harmless.

Optional Feature:
- Macro: MEM_WB_RETIRE_CNT_EN
- Defined:
  - o_retired_cnt exists.
  - Increments by 1 on each edge that captures i_valid=1 with i_halt=0, flush=0 and o_end_program=0.
  - Saturates at all ones (no wrap).
  - Clears only on reset.
- Not defined: the port and the counter logic are absent. All other behaviour is identical.

Test Plan:
- Reset: hold i_reset=1 for a random 1..20 ticks, then release → every output reads 0, including o_end_program.
- ALU write-back: i_valid=1, i_reg_wr=1, i_rd_addr=5, i_alu_result=32'h0000_00A5, i_enable=1 for 1 edge → next cycle o_reg_wr=1, o_rd_addr=5, o_wb_data=32'h0000_00A5.
- Source select and $zero suppression:
  - i_mem_to_reg=1, i_mem_rd=32'hFFFF_FF80, i_alu_result=32'h10 → o_wb_data=32'hFFFF_FF80.
  - Same inputs with i_link=1, i_return_addr=32'h48 → o_wb_data=32'h48.
  - i_rd_addr=0 → o_reg_wr=0.
- Stall/flush:
  - Capture rd=7, then i_enable=0 for 5 edges with changing inputs → outputs hold rd=7.
  - Then i_flush=1 together with i_enable=1 → o_valid=0, o_reg_wr=0.
- HALT: push 3 valid writes, then i_halt=1 with i_valid=1, then 4 more valid writes.
  - o_end_program=1 from the HALT capture onward.
  - o_reg_wr=0 and outputs frozen for the remaining writes.
  - With the macro defined, o_retired_cnt=3.
  - Pulse i_reset → o_end_program=0, o_retired_cnt=0.
- Counter saturation (macro defined, CNT_SIZE=4): issue 20 valid non-halt instructions → o_retired_cnt stops at 4'hF.
